// File: rtl/morph_pkg.sv
// Shared types and helpers for the streaming 3x3 binary morphology filter.
package morph_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_ERODE  = 2'd1,
        MODE_DILATE = 2'd2,
        MODE_COUNT  = 2'd3
    } morph_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_e;

    function automatic logic [3:0] popcount9(input logic [8:0] bits);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 9; i++) begin
            n = n + {3'd0, bits[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/morph_line_buffer.sv
// One-line delay for a 1-bit pixel stream: circular buffer with a shared
// read/write pointer, so the bit read out was written DEPTH shifts earlier.
module morph_line_buffer #(
    parameter int DEPTH = 640
) (
    input  logic clk,
    input  logic reset,
    input  logic shift_en_i,
    input  logic bit_i,
    output logic bit_o
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    logic          mem_q [DEPTH];
    logic [PW-1:0] ptr_q;

    assign bit_o = mem_q[ptr_q];

    // NOTE: sequential state is always written with <= so every register samples
    // the pre-edge values; blocking = here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (shift_en_i) begin
            ptr_q <= (ptr_q == PTR_LAST) ? '0 : ptr_q + PW'(1);
        end
    end

    // NOTE: the storage array has no reset on purpose; stale bits only ever reach
    // window positions that the border mask overrides, and this keeps it RAM-mappable.
    always_ff @(posedge clk) begin
        if (shift_en_i) begin
            mem_q[ptr_q] <= bit_i;
        end
    end

endmodule

// File: rtl/morph_stream_filter.sv
// Streaming 3x3 binary erode/dilate/count/bypass filter with valid/ready on both
// sides; the centre pixel lags the input by IMG_W+1 beats and a FLUSH phase drains it.
module morph_stream_filter
    import morph_pkg::*;
#(
    parameter int PIX_W  = 4,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter bit BORDER = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  morph_mode_e       mode,
    input  logic [3:0]        count_thresh,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PIX_W-1:0]  in_pixel,
    input  logic              in_sof,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PIX_W-1:0]  out_pixel,
    output logic              out_sof,
    output logic              out_eof,
    output logic              busy,
    output logic              sync_err
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    state_e          state_q, state_d;
    morph_mode_e     mode_q;
    logic [3:0]      thresh_q;
    logic [XW-1:0]   in_x_q, ox_q;
    logic [YW-1:0]   in_y_q, oy_q;
    logic [2:0][2:0] win_q, win_d, nbr;
    logic            out_valid_q, out_bit_q, out_sof_q, out_eof_q, sync_err_q;

    logic slot_free, accept, start, shift, produce;
    logic shift_in, lb1_out, lb2_out, result;
    logic [8:0] flat;

    // Output process: handshake and datapath enables derived from the state.
    // NOTE: every combinational output gets a default before the case so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        slot_free = ~out_valid_q | out_ready;
        in_ready  = (state_q != FLUSH) && slot_free;
        busy      = (state_q != IDLE);
        accept    = in_valid && in_ready;
        start     = accept && in_sof;
        shift     = 1'b0;
        produce   = 1'b0;
        unique case (state_q)
            IDLE:  shift = start;
            FILL: begin
                shift   = accept;
                produce = accept && !in_sof && (in_x_q == XW'(1)) && (in_y_q == YW'(1));
            end
            RUN: begin
                shift   = accept;
                produce = accept && !in_sof;
            end
            FLUSH: begin
                shift   = slot_free && !(out_valid_q && out_eof_q);
                produce = shift;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start) state_d = FILL;
            FILL:  if (start) state_d = FILL;
                   else if (produce) state_d = RUN;
            RUN:   if (start) state_d = FILL;
                   else if (accept && in_x_q == X_LAST && in_y_q == Y_LAST) state_d = FLUSH;
            FLUSH: if (out_valid_q && out_eof_q && out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign shift_in = (state_q == FLUSH) ? BORDER : |in_pixel;

    morph_line_buffer #(.DEPTH(IMG_W)) u_lb1 (
        .clk(clk), .reset(reset), .shift_en_i(shift), .bit_i(shift_in), .bit_o(lb1_out)
    );
    morph_line_buffer #(.DEPTH(IMG_W)) u_lb2 (
        .clk(clk), .reset(reset), .shift_en_i(shift), .bit_i(lb1_out), .bit_o(lb2_out)
    );

    // Row 0 is the line above the centre, column 2 the pixel to its right.
    always_comb begin
        win_d    = win_q;
        win_d[0] = {lb2_out, win_q[0][2:1]};
        win_d[1] = {lb1_out, win_q[1][2:1]};
        win_d[2] = {shift_in, win_q[2][2:1]};
        nbr      = win_d;
        if (oy_q == '0)     nbr[0] = {3{BORDER}};
        if (oy_q == Y_LAST) nbr[2] = {3{BORDER}};
        for (int r = 0; r < 3; r++) begin
            if (ox_q == '0)     nbr[r][0] = BORDER;
            if (ox_q == X_LAST) nbr[r][2] = BORDER;
        end
        flat = {nbr[2], nbr[1], nbr[0]};
        unique case (mode_q)
            MODE_BYPASS: result = nbr[1][1];
            MODE_ERODE:  result = &flat;
            MODE_DILATE: result = |flat;
            default:     result = (popcount9(flat) >= thresh_q);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            mode_q      <= MODE_BYPASS;
            thresh_q    <= 4'd1;
            in_x_q      <= '0;
            in_y_q      <= '0;
            ox_q        <= '0;
            oy_q        <= '0;
            win_q       <= '0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_err_q <= start && (state_q == FILL || state_q == RUN);
            if (shift) win_q <= win_d;
            if (start) begin
                mode_q   <= mode;
                thresh_q <= (count_thresh == 4'd0) ? 4'd1 : count_thresh;
                in_x_q   <= XW'(1);
                in_y_q   <= '0;
                ox_q     <= '0;
                oy_q     <= '0;
            end else begin
                if (accept && (state_q == FILL || state_q == RUN)) begin
                    if (in_x_q == X_LAST) begin
                        in_x_q <= '0;
                        in_y_q <= in_y_q + YW'(1);
                    end else begin
                        in_x_q <= in_x_q + XW'(1);
                    end
                end
                if (produce) begin
                    if (ox_q == X_LAST) begin
                        ox_q <= '0;
                        oy_q <= (oy_q == Y_LAST) ? '0 : oy_q + YW'(1);
                    end else begin
                        ox_q <= ox_q + XW'(1);
                    end
                end
            end
            // A restart drops whatever the old frame still had pending.
            if (start) begin
                out_valid_q <= 1'b0;
            end else if (produce) begin
                out_valid_q <= 1'b1;
                out_bit_q   <= result;
                out_sof_q   <= (ox_q == '0) && (oy_q == '0);
                out_eof_q   <= (ox_q == X_LAST) && (oy_q == Y_LAST);
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_pixel = {PIX_W{out_bit_q}};
    assign out_sof   = out_valid_q & out_sof_q;
    assign out_eof   = out_valid_q & out_eof_q;
    assign sync_err  = sync_err_q;

endmodule
